// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit radices for the lap timer
package stopwatch_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Index 0 is 1/100 s, index 5 is tens of minutes.
  typedef logic [NUM_DIGITS-1:0][3:0] bcd_time_t;

  localparam int unsigned DIGIT_RADIX [NUM_DIGITS] = '{10, 10, 10, 6, 10, 6};

  function automatic logic [3:0] sat_digit(input logic [3:0] v, input int unsigned radix);
    logic [3:0] top;
    top = 4'(radix - 1);
    return (v > top) ? top : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with saturating load
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned RADIX = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       at_term
);

  localparam logic [3:0] TOP = 4'(RADIX - 1);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = sat_digit(load_val, RADIX);
    end else if (en) begin
      if (dir) value_d = (value_q == 4'd0) ? TOP : value_q - 4'd1;
      else     value_d = (value_q == TOP) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;
  // Terminal value is where this digit hands a carry/borrow to the next one.
  assign at_term = dir ? (value_q == 4'd0) : (value_q == TOP);

endmodule

// File: rtl/lap_timer.sv
// rtl/lap_timer.sv - BCD stopwatch/countdown timer with a lap capture FIFO
module lap_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        count_down,
  input  logic        load,
  input  logic [23:0] preset,
  input  logic        lap,
  input  logic        lap_rd,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5,
  output logic [23:0] lap_data,
  output logic        lap_valid,
  output logic        lap_full,
  output logic        lap_overflow,
  output logic        expired
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam bcd_time_t LAST_TICK = 24'h000001;

  logic [PW-1:0] pre_q, pre_d;
  logic exp_q, exp_d;
  logic tick, hold;
  bcd_time_t cur;
  logic [NUM_DIGITS-1:0] at_term, carry;

  assign tick = run && (pre_q == PRE_TOP);
  // In down mode every digit at terminal means 00:00.00: freeze instead of wrapping.
  assign hold = count_down && (&at_term);

  always_comb begin
    carry[0] = tick && !hold;
    for (int i = 1; i < NUM_DIGITS; i++) carry[i] = carry[i-1] && at_term[i-1];
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(.RADIX(DIGIT_RADIX[i])) u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (carry[i]),
      .dir      (count_down),
      .load     (load),
      .load_val (preset[4*i +: 4]),
      .value    (cur[i]),
      .at_term  (at_term[i])
    );
  end

  always_comb begin
    pre_d = pre_q;
    exp_d = exp_q;
    if (load) begin
      pre_d = '0;
      exp_d = 1'b0;
    end else begin
      if (run) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick && count_down && cur == LAST_TICK) exp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      exp_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      exp_q <= exp_d;
    end
  end

  bcd_time_t mem [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (cnt_q == CW'(LAP_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A lap on a full FIFO still lands when the head is popped in the same cycle.
  assign push = lap && (!fifo_full || lap_rd);
  assign pop  = lap_rd && !fifo_empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (load)                             ovf_d = 1'b0;
    else if (lap && fifo_full && !lap_rd) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cur;
  end

  assign digit0       = cur[0];
  assign digit1       = cur[1];
  assign digit2       = cur[2];
  assign digit3       = cur[3];
  assign digit4       = cur[4];
  assign digit5       = cur[5];
  assign lap_data     = fifo_empty ? '0 : mem[rd_ptr_q];
  assign lap_valid    = !fifo_empty;
  assign lap_full     = fifo_full;
  assign lap_overflow = ovf_q;
  assign expired      = exp_q;

endmodule

// File: tb/tb_lap_timer.sv
// tb/tb_lap_timer.sv - randomized self-checking bench for lap_timer
module tb_lap_timer;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 4;

  logic clk = 1'b0;
  logic reset, run, count_down, load, lap, lap_rd;
  logic [23:0] preset;
  logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic [23:0] lap_data;
  logic lap_valid, lap_full, lap_overflow, expired;
  logic [23:0] dig;

  int errors = 0;
  int checks = 0;

  // Reference state: time in hundredths of a second, plain prescaler count, queue FIFO.
  int m_time, m_pre;
  bit m_exp, m_ovf;
  logic [23:0] m_q[$];

  lap_timer #(.TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .count_down(count_down), .load(load),
    .preset(preset), .lap(lap), .lap_rd(lap_rd),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit4(digit4), .digit5(digit5), .lap_data(lap_data), .lap_valid(lap_valid),
    .lap_full(lap_full), .lap_overflow(lap_overflow), .expired(expired)
  );

  assign dig = {digit5, digit4, digit3, digit2, digit1, digit0};

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int h, s, m;
    h = t % 100;
    s = (t / 100) % 60;
    m = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic int preset_to_time(input logic [23:0] p);
    int lim [6] = '{9, 9, 9, 5, 9, 5};
    int w   [6] = '{1, 10, 100, 1000, 6000, 60000};
    int t, d;
    t = 0;
    for (int i = 0; i < 6; i++) begin
      d = int'(p[4*i +: 4]);
      if (d > lim[i]) d = lim[i];
      t += d * w[i];
    end
    return t;
  endfunction

  task automatic model_reset();
    m_time = 0; m_pre = 0; m_exp = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit tk, was_full;
    tk = run && (m_pre == TICK_DIV - 1);
    was_full = (m_q.size() == LAP_DEPTH);
    if (lap && was_full && !lap_rd) m_ovf = 1;
    if (lap_rd && m_q.size() > 0) void'(m_q.pop_front());
    if (lap && (!was_full || lap_rd)) m_q.push_back(to_bcd(m_time));
    if (load) begin
      m_time = preset_to_time(preset);
      m_pre = 0; m_exp = 0; m_ovf = 0;
    end else begin
      if (run) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (!count_down) m_time = (m_time + 1) % 360000;
        else if (m_time > 0) begin
          m_time--;
          if (m_time == 0) m_exp = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; count_down = 0; load = 0; lap = 0; lap_rd = 0; preset = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dig !== 24'h0) begin errors++; $display("FAIL reset_digits got=%h want=%h", dig, 24'h0); end
    checks++;
    if ({lap_valid, lap_full, lap_overflow, expired} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got=%b want=0000", {lap_valid, lap_full, lap_overflow, expired}); end
    checks++;
    if (lap_data !== 24'h0) begin errors++; $display("FAIL reset_lap_data got=%h want=%h", lap_data, 24'h0); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_minute_rollover();
    do_reset();
    clear_inputs();
    run = 1;
    repeat (23999) cycle();
    checks++;
    if (dig !== 24'h005999) begin errors++; $display("FAIL minute_pre got=%h want=%h", dig, 24'h005999); end
    cycle();
    checks++;
    if (dig !== 24'h010000) begin errors++; $display("FAIL minute_roll got=%h want=%h", dig, 24'h010000); end
  endtask

  task automatic test_down_expire();
    count_down = 1; load = 1; preset = 24'h000003;
    cycle();
    load = 0; run = 1;
    checks++;
    if (dig !== 24'h000003 || expired !== 1'b0)
      begin errors++; $display("FAIL down_load got=%h/%b want=000003/0", dig, expired); end
    repeat (11) cycle();
    checks++;
    if (dig !== 24'h000001 || expired !== 1'b0)
      begin errors++; $display("FAIL down_before got=%h/%b want=000001/0", dig, expired); end
    cycle();
    checks++;
    if (dig !== 24'h000000 || expired !== 1'b1)
      begin errors++; $display("FAIL down_expire got=%h/%b want=000000/1", dig, expired); end
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if (dig !== 24'h000000 || expired !== 1'b1)
        begin errors++; $display("FAIL down_hold cyc=%0d got=%h/%b want=000000/1", i, dig, expired); end
    end
  endtask

  task automatic test_up_wrap();
    run = 0; count_down = 0; load = 1; preset = 24'h595999;
    cycle();
    load = 0;
    checks++;
    if (dig !== 24'h595999 || expired !== 1'b0)
      begin errors++; $display("FAIL wrap_load got=%h/%b want=595999/0", dig, expired); end
    run = 1;
    repeat (3) cycle();
    checks++;
    if (dig !== 24'h595999) begin errors++; $display("FAIL wrap_pre got=%h want=%h", dig, 24'h595999); end
    cycle();
    checks++;
    if (dig !== 24'h000000 || expired !== 1'b0)
      begin errors++; $display("FAIL wrap_tick got=%h/%b want=000000/0", dig, expired); end
  endtask

  task automatic test_lap_fifo();
    logic [23:0] want [5];
    do_reset();
    clear_inputs();
    run = 1;
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(1, 40)) cycle();
      want[k] = to_bcd(m_time);
      lap = 1;
      cycle();
      lap = 0;
    end
    checks++;
    if (lap_full !== 1'b1 || lap_overflow !== 1'b1)
      begin errors++; $display("FAIL lap_full_ovf got=%b%b want=11", lap_full, lap_overflow); end
    run = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (lap_valid !== 1'b1 || lap_data !== want[k])
        begin errors++; $display("FAIL lap_pop%0d got=%b/%h want=1/%h", k, lap_valid, lap_data, want[k]); end
      lap_rd = 1;
      cycle();
      lap_rd = 0;
    end
    checks++;
    if (lap_valid !== 1'b0 || lap_data !== 24'h0)
      begin errors++; $display("FAIL lap_empty got=%b/%h want=0/000000", lap_valid, lap_data); end
    lap_rd = 1;
    cycle();
    lap_rd = 0;
    checks++;
    if (lap_valid !== 1'b0 || lap_full !== 1'b0 || lap_overflow !== 1'b1)
      begin errors++; $display("FAIL lap_rd_empty got=%b%b%b want=001", lap_valid, lap_full, lap_overflow); end
    run = 1;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 20)) cycle();
      want[k] = to_bcd(m_time);
      lap = 1;
      cycle();
      lap = 0;
    end
    repeat ($urandom_range(1, 20)) cycle();
    want[4] = to_bcd(m_time);
    lap = 1; lap_rd = 1;
    cycle();
    lap = 0; lap_rd = 0; run = 0;
    checks++;
    if (lap_full !== 1'b1 || lap_data !== want[1])
      begin errors++; $display("FAIL lap_rw_full got=%b/%h want=1/%h", lap_full, lap_data, want[1]); end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (lap_data !== want[k]) begin errors++; $display("FAIL lap_rw_pop%0d got=%h want=%h", k, lap_data, want[k]); end
      lap_rd = 1;
      cycle();
      lap_rd = 0;
    end
    checks++;
    if (lap_valid !== 1'b0) begin errors++; $display("FAIL lap_rw_drain got=%b want=0", lap_valid); end
  endtask

  task automatic test_load_saturate();
    clear_inputs();
    load = 1; preset = 24'h079999;
    cycle();
    load = 0;
    checks++;
    if (dig !== 24'h075999) begin errors++; $display("FAIL load_sat got=%h want=%h", dig, 24'h075999); end
    run = 1;
    repeat ($urandom_range(5, 50)) cycle();
    lap = 1;
    cycle();
    lap = 0;
    repeat ($urandom_range(1, 10)) cycle();
    lap = 1; lap_rd = 1;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (dig !== 24'h0 || lap_data !== 24'h0)
      begin errors++; $display("FAIL async_reset_data got=%h/%h want=0/0", dig, lap_data); end
    checks++;
    if ({lap_valid, lap_full, lap_overflow, expired} !== 4'b0)
      begin errors++; $display("FAIL async_reset_flags got=%b want=0000", {lap_valid, lap_full, lap_overflow, expired}); end
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    checks++;
    if (lap_valid !== 1'b0 || dig !== 24'h0)
      begin errors++; $display("FAIL reset_no_push got=%b/%h want=0/0", lap_valid, dig); end
  endtask

  task automatic test_random();
    logic [23:0] head;
    do_reset();
    clear_inputs();
    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 2) count_down = ~count_down;
      load   = ($urandom_range(0, 99) < 2);
      preset = $urandom_range(0, 1) ? {20'h0, 4'($urandom_range(0, 15))} : 24'($urandom());
      lap    = ($urandom_range(0, 9) == 0);
      lap_rd = ($urandom_range(0, 9) == 0);
      cycle();
      head = (m_q.size() > 0) ? m_q[0] : 24'h0;
      checks++;
      if (dig !== to_bcd(m_time) || expired !== m_exp)
        begin errors++; $display("FAIL rand_time cyc=%0d got=%h/%b want=%h/%b", i, dig, expired, to_bcd(m_time), m_exp); end
      checks++;
      if (lap_data !== head || lap_valid !== (m_q.size() > 0) ||
          lap_full !== (m_q.size() == LAP_DEPTH) || lap_overflow !== m_ovf)
        begin errors++; $display("FAIL rand_fifo cyc=%0d got=%h/%b%b%b want=%h/%b%b%b", i, lap_data,
          lap_valid, lap_full, lap_overflow, head, m_q.size() > 0, m_q.size() == LAP_DEPTH, m_ovf); end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_minute_rollover();
    test_down_expire();
    test_up_wrap();
    test_lap_fifo();
    test_load_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
